cdb_arbiter: RTL and testbench

Completion-side arbiter that shares the `N_WAY` CDB slots among `N_REQ` functional-unit requesters. Each requester owns a one-entry holding register. Every cycle up to `N_WAY` held destination tags are selected in round-robin order and driven as `complete_dest_tag` into the ROB top level, where the CDB register latches them. The block guarantees no completion is lost when more units finish than there are CDB slots, and that no requester starves.

---
 rtl/cdb_arbiter.sv | 90 +++++++++
 tb/tb_cdb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin completion arbiter: one holding register per functional unit,
// up to N_WAY held tags per cycle are driven onto the CDB slots.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

module cdb_arbiter #(
  parameter int N_REQ    = 4,
  parameter int N_WAY    = `N_WAY,
  parameter int TAG_BITS = `CDB_BITS
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][TAG_BITS-1:0]   req_tag,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_WAY-1:0][TAG_BITS-1:0]   complete_dest_tag,
  output logic [$clog2(N_WAY):0]           cdb_num,
  output logic [N_REQ-1:0]                 grant
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = $clog2(N_WAY) + 1;
  localparam int SLOT_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  logic [N_REQ-1:0]                held;
  logic [N_REQ-1:0][TAG_BITS-1:0]  hold_tag;
  logic [PTR_W-1:0]                ptr;

  logic [N_REQ-1:0]                grant_raw;
  logic [N_WAY-1:0][TAG_BITS-1:0]  slot_raw;
  logic [CNT_W-1:0]                num_raw;
  logic [PTR_W-1:0]                next_ptr;
  logic [PTR_W-1:0]                idx;
  logic [SLOT_W-1:0]               slot_idx;
  int                              idx_sum;

  // Scan from ptr in wrap-around order; the k-th held entry found fills slot k.
  always_comb begin
    grant_raw = '0;
    slot_raw  = '0;
    num_raw   = '0;
    next_ptr  = ptr;
    idx       = '0;
    slot_idx  = '0;
    idx_sum   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_sum = int'(ptr) + k;
      idx     = PTR_W'((idx_sum >= N_REQ) ? idx_sum - N_REQ : idx_sum);
      if (held[idx] && (int'(num_raw) < N_WAY)) begin
        slot_idx           = SLOT_W'(num_raw);
        grant_raw[idx]     = 1'b1;
        slot_raw[slot_idx] = hold_tag[idx];
        num_raw            = num_raw + CNT_W'(1);
        next_ptr           = PTR_W'(((int'(idx) + 1) == N_REQ) ? 0 : int'(idx) + 1);
      end
    end
  end

  assign grant             = reset ? '0 : grant_raw;
  assign complete_dest_tag = reset ? '0 : slot_raw;
  assign cdb_num           = reset ? '0 : num_raw;
  assign req_ready         = (reset || squash) ? '0 : (~held | grant_raw);

  // An accept into a granted entry overrides its release.
  always_ff @(posedge clock) begin
    if (reset) begin
      held     <= '0;
      hold_tag <= '0;
      ptr      <= '0;
    end else if (squash) begin
      held <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (req_tag[i] != '0)) begin
          held[i]     <= 1'b1;
          hold_tag[i] <= req_tag[i];
        end else if (grant_raw[i]) begin
          held[i] <= 1'b0;
        end
      end
      if (num_raw != '0) ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (N_REQ=4, N_WAY=2): expected CDB tags are
// queued by the stimulus and popped by an independent monitor.
module tb_cdb_arbiter;

  localparam int N_REQ = 4;
  localparam int N_WAY = 2;
  localparam int TB    = 6;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    squash;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0][TB-1:0] req_tag;
  logic [N_REQ-1:0]        req_ready;
  logic [N_WAY-1:0][TB-1:0] complete_dest_tag;
  logic [$clog2(N_WAY):0]  cdb_num;
  logic [N_REQ-1:0]        grant;

  int total = 0;
  int bad   = 0;
  logic [TB-1:0] exp_q[$];
  int cur[N_REQ];
  int gap;
  logic [N_REQ-1:0] exp_g;

  cdb_arbiter #(.N_REQ(N_REQ), .N_WAY(N_WAY), .TAG_BITS(TB)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .complete_dest_tag(complete_dest_tag), .cdb_num(cdb_num), .grant(grant)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every visible CDB slot must match the next queued tag, unused slots are 0.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        for (int s = 0; s < N_WAY; s++) begin
          if (s < int'(cdb_num)) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_tag actual=%0d required=none", complete_dest_tag[s]);
            end else begin
              chk("cdb_tag", int'(complete_dest_tag[s]), int'(exp_q.pop_front()));
            end
          end else begin
            chk("unused_slot", int'(complete_dest_tag[s]), 0);
          end
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    squash    = 1'b0;
    req_valid = 4'b1111;
    req_tag   = {6'd13, 6'd12, 6'd11, 6'd10};

    // reset held two cycles with all requesters valid
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      #3;
      chk("rst_num", int'(cdb_num), 0);
      chk("rst_grant", int'(grant), 0);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_slots", int'(complete_dest_tag), 0);
    end
    step(); reset = 1'b0; req_valid = '0; #2;
    chk("post_rst_ready", int'(req_ready), 4'b1111);
    chk("post_rst_num", int'(cdb_num), 0);
    chk("post_rst_ptr", int'(dut.ptr), 0);

    // single request on requester 2
    step(); req_valid = 4'b0100; req_tag[2] = 6'd33; exp_q.push_back(6'd33); #2;
    chk("single_pre_num", int'(cdb_num), 0);
    step(); req_valid = '0; #2;
    chk("single_num", int'(cdb_num), 1);
    chk("single_grant", int'(grant), 4'b0100);
    chk("single_slot1", int'(complete_dest_tag[1]), 0);
    step(); #2;
    chk("single_ptr", int'(dut.ptr), 3);
    chk("single_after_num", int'(cdb_num), 0);

    // oversubscription from ptr=0
    step(); reset = 1'b1;
    step(); reset = 1'b0; req_valid = 4'b1111; req_tag = {6'd36, 6'd35, 6'd34, 6'd33};
    exp_q.push_back(6'd33); exp_q.push_back(6'd34);
    exp_q.push_back(6'd35); exp_q.push_back(6'd36); #2;
    chk("over_ptr0", int'(dut.ptr), 0);
    step(); req_valid = '0; #2;
    chk("over_c1_num", int'(cdb_num), 2);
    chk("over_c1_ready", int'(req_ready), 4'b0011);
    chk("over_c1_grant", int'(grant), 4'b0011);
    step(); #2;
    chk("over_c2_num", int'(cdb_num), 2);
    chk("over_c2_grant", int'(grant), 4'b1100);
    step(); #2;
    chk("over_c3_num", int'(cdb_num), 0);
    chk("over_c3_ptr", int'(dut.ptr), 0);

    // back-to-back on requester 0
    step(); req_valid = 4'b0001; req_tag[0] = 6'd40;
    exp_q.push_back(6'd40); exp_q.push_back(6'd41); exp_q.push_back(6'd42);
    step(); req_tag[0] = 6'd41; #2;
    chk("b2b_num0", int'(cdb_num), 1);
    chk("b2b_grant0", int'(grant), 4'b0001);
    chk("b2b_ready0", int'(req_ready[0]), 1);
    step(); req_tag[0] = 6'd42; #2;
    chk("b2b_grant1", int'(grant), 4'b0001);
    step(); req_valid = '0; #2;
    chk("b2b_grant2", int'(grant), 4'b0001);
    step(); #2;
    chk("b2b_idle_num", int'(cdb_num), 0);
    chk("b2b_ptr", int'(dut.ptr), 1);

    // fairness: all requesters kept full, ptr starts at 1
    step(); req_valid = 4'b1111;
    for (int i = 0; i < N_REQ; i++) begin
      cur[i] = 20 + i;
      req_tag[i] = TB'(cur[i]);
    end
    gap = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      if ((j % 2) == 0) begin
        exp_g = 4'b0110;
        exp_q.push_back(TB'(cur[1])); exp_q.push_back(TB'(cur[2]));
      end else begin
        exp_g = 4'b1001;
        exp_q.push_back(TB'(cur[3])); exp_q.push_back(TB'(cur[0]));
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (exp_g[i]) begin
          cur[i] = cur[i] + 4;
          req_tag[i] = TB'(cur[i]);
        end
      end
      #2;
      chk("fair_grant", int'(grant), int'(exp_g));
      chk("fair_ready", int'(req_ready), int'(exp_g));
      if (grant[0]) gap = 0; else gap++;
      chk("fair_gap_ok", int'(gap < 2), 1);
    end
    step(); req_valid = '0;
    exp_q.push_back(TB'(cur[1])); exp_q.push_back(TB'(cur[2])); #2;
    chk("drain_grant0", int'(grant), 4'b0110);
    step(); exp_q.push_back(TB'(cur[3])); exp_q.push_back(TB'(cur[0])); #2;
    chk("drain_grant1", int'(grant), 4'b1001);
    step(); #2;
    chk("drain_num", int'(cdb_num), 0);
    chk("drain_ptr", int'(dut.ptr), 1);

    // tag 0 is dropped
    step(); req_valid = 4'b0010; req_tag[1] = '0; #2;
    chk("tag0_ready", int'(req_ready), 4'b1111);
    step(); req_valid = '0; #2;
    chk("tag0_num", int'(cdb_num), 0);
    chk("tag0_grant", int'(grant), 0);

    // squash with three held entries, same-cycle request discarded
    step(); req_valid = 4'b0111; req_tag[0] = 6'd50; req_tag[1] = 6'd51; req_tag[2] = 6'd52;
    step(); squash = 1'b1; req_valid = 4'b1000; req_tag[3] = 6'd53;
    exp_q.push_back(6'd51); exp_q.push_back(6'd52); #2;
    chk("sq_num", int'(cdb_num), 2);
    chk("sq_grant", int'(grant), 4'b0110);
    chk("sq_ready", int'(req_ready), 0);
    step(); squash = 1'b0; req_valid = '0; #2;
    chk("sq_after_num", int'(cdb_num), 0);
    chk("sq_after_ready", int'(req_ready), 4'b1111);
    chk("sq_after_ptr", int'(dut.ptr), 1);

    // reset mid-operation: held tags never reach the CDB
    step(); req_valid = 4'b1111; req_tag = {6'd63, 6'd62, 6'd61, 6'd60};
    step(); reset = 1'b1; req_valid = '0; #2;
    chk("mid_rst_num", int'(cdb_num), 0);
    chk("mid_rst_grant", int'(grant), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    step(); reset = 1'b0; #2;
    chk("mid_after_num", int'(cdb_num), 0);
    chk("mid_after_ptr", int'(dut.ptr), 0);
    chk("mid_after_ready", int'(req_ready), 4'b1111);
    for (int c = 0; c < 3; c++) begin
      step(); #2;
      chk("mid_idle_num", int'(cdb_num), 0);
    end

    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
